pipe_wb_buf: RTL and testbench

MEM→WB pipeline buffer: a small FIFO that accepts write-back records (enable, 32-bit value, 5-bit register index) from the MEM stage and hands them to the WB stage. The read side drives the buf_avail / buf_re / buf_rack handshake that the WB stage consumes. Both sides use level-request / single-cycle-pulse-acknowledge handshakes, so consumers that act on acknowledge edges see one clean edge per transfer.

---
 rtl/pipe_wb_buf.sv | 93 +++++++++
 tb/tb_pipe_wb_buf.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_wb_buf.sv
// MEM->WB write-back record buffer: DEPTH-entry FIFO with level/pulse-ack handshakes on both sides.
// Optional PIPE_WB_BUF_BYPASS_EN lets a record go straight to the WB outputs when the buffer is empty.
module pipe_wb_buf #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int IW    = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_req,
    input  logic                     wr_wb_e,
    input  logic [DW-1:0]            wr_data,
    input  logic [IW-1:0]            wr_idx,
    output logic                     wr_ack,
    output logic                     buf_avail,
    input  logic                     buf_re,
    output logic                     buf_rack,
    output logic                     wb_e,
    output logic [DW-1:0]            din,
    output logic [IW-1:0]            idxin,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic          e;
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
    } rec_t;

    rec_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;
    logic            bypass;
    logic            store;
    rec_t            wr_rec;
    rec_t            rd_rec;

    // The ack-low guard enforces one idle cycle between transfers on each side.
    assign push_ok = wr_req && (level != LW'(DEPTH)) && !wr_ack;
    assign pop_ok  = buf_re && (level != '0) && !buf_rack;

`ifdef PIPE_WB_BUF_BYPASS_EN
    assign bypass  = push_ok && (level == '0) && buf_re && !buf_rack;
`else
    assign bypass  = 1'b0;
`endif

    assign store     = push_ok && !bypass;
    assign buf_avail = (level != '0);
    assign wr_rec    = '{e: wr_wb_e, data: wr_data, idx: wr_idx};
    assign rd_rec    = mem[rd_ptr];

    // Storage carries no reset; only pointers/level decide what is valid.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= wr_rec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            wr_ack   <= 1'b0;
            buf_rack <= 1'b0;
            wb_e     <= 1'b0;
            din      <= '0;
            idxin    <= '0;
        end else begin
            wr_ack   <= push_ok;
            buf_rack <= pop_ok || bypass;
            if (store)  wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({store, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (pop_ok) begin
                wb_e  <= rd_rec.e;
                din   <= rd_rec.data;
                idxin <= rd_rec.idx;
            end else if (bypass) begin
                wb_e  <= wr_wb_e;
                din   <= wr_data;
                idxin <= wr_idx;
            end
        end
    end
endmodule

// File: tb/tb_pipe_wb_buf.sv
// Randomized + directed bench for pipe_wb_buf against a queue-based reference model.
// Honours PIPE_WB_BUF_BYPASS_EN the same way the design does.
module tb_pipe_wb_buf;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int IW    = 5;
`ifdef PIPE_WB_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   wr_req, wr_wb_e, buf_re;
    logic [DW-1:0]          wr_data;
    logic [IW-1:0]          wr_idx;
    logic                   wr_ack, buf_avail, buf_rack, wb_e;
    logic [DW-1:0]          din;
    logic [IW-1:0]          idxin;
    logic [$clog2(DEPTH):0] level;

    pipe_wb_buf #(.DEPTH(DEPTH), .DW(DW), .IW(IW)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_wb_e(wr_wb_e), .wr_data(wr_data), .wr_idx(wr_idx),
        .wr_ack(wr_ack), .buf_avail(buf_avail), .buf_re(buf_re), .buf_rack(buf_rack),
        .wb_e(wb_e), .din(din), .idxin(idxin), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          e;
        logic [DW-1:0] d;
        logic [IW-1:0] i;
    } rec_t;

    rec_t          q[$];
    logic          m_wack, m_rack, m_e;
    logic [DW-1:0] m_d;
    logic [IW-1:0] m_i;
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_wack = 0; m_rack = 0; m_e = 0; m_d = '0; m_i = '0;
    endtask

    // One clock edge of the reference behaviour, using the inputs present at the edge.
    task automatic model_edge();
        bit   push, pop, byp;
        rec_t r;
        push = wr_req && (q.size() < DEPTH) && !m_wack;
        pop  = buf_re && (q.size() > 0) && !m_rack;
        byp  = BYP && push && (q.size() == 0) && buf_re && !m_rack;
        r    = '{e: wr_wb_e, d: wr_data, i: wr_idx};
        if (pop) begin
            rec_t o;
            o = q.pop_front();
            m_e = o.e; m_d = o.d; m_i = o.i;
        end
        if (byp) begin
            m_e = r.e; m_d = r.d; m_i = r.i;
        end else if (push) begin
            q.push_back(r);
        end
        m_wack = push;
        m_rack = pop || byp;
    endtask

    task automatic compare();
        chk("level",    64'(level),     64'(q.size()));
        chk("avail",    64'(buf_avail), 64'(q.size() != 0));
        chk("wr_ack",   64'(wr_ack),    64'(m_wack));
        chk("buf_rack", 64'(buf_rack),  64'(m_rack));
        chk("wb_e",     64'(wb_e),      64'(m_e));
        chk("din",      64'(din),       64'(m_d));
        chk("idxin",    64'(idxin),     64'(m_i));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    // Asynchronous reset pulse placed mid low-phase, away from any edge.
    task automatic do_reset();
        #2;
        rst = 1; wr_req = 0; buf_re = 0;
        model_reset();
        #1;
        compare();
        chk("rst_din", 64'(din), 64'(0));
        rst = 0;
    endtask

    task automatic push_rec(input logic e, input logic [DW-1:0] d, input logic [IW-1:0] i);
        int n = 0;
        wr_wb_e = e; wr_data = d; wr_idx = i; wr_req = 1;
        do begin tick(); n++; end while (!wr_ack && n < 20);
        if (!wr_ack) chk("push_timeout", 64'(0), 64'(1));
        wr_req = 0;
        tick();
    endtask

    task automatic pop_one(input string tag, input logic [DW-1:0] exp_d);
        int n = 0;
        buf_re = 1;
        do begin tick(); n++; end while (!buf_rack && n < 20);
        if (!buf_rack) chk({tag, "_timeout"}, 64'(0), 64'(1));
        chk(tag, 64'(din), 64'(exp_d));
        buf_re = 0;
        tick();
    endtask

    initial begin
        rst = 1; wr_req = 0; wr_wb_e = 0; wr_data = '0; wr_idx = '0; buf_re = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        rst = 0;

        // Reset while wr_ack is high
        wr_wb_e = 1; wr_data = 32'hDEAD; wr_idx = 5'd3; wr_req = 1;
        tick();
        chk("rst_mid_ack", 64'(wr_ack), 64'(1));
        do_reset();
        chk("rst_level", 64'(level), 64'(0));
        buf_re = 1;
        repeat (2) tick();
        chk("rst_no_rack", 64'(buf_rack), 64'(0));
        buf_re = 0;
        tick();

        // Single transfer
        push_rec(1'b1, 32'h2A, 5'd5);
        chk("single_lvl1", 64'(level), 64'(1));
        buf_re = 1;
        tick();
        chk("single_rack", 64'(buf_rack), 64'(1));
        chk("single_e",    64'(wb_e),     64'(1));
        chk("single_din",  64'(din),      64'(32'h2A));
        chk("single_idx",  64'(idxin),    64'(5));
        tick();
        chk("single_once", 64'(buf_rack), 64'(0));
        chk("single_lvl0", 64'(level),    64'(0));
        buf_re = 0;
        tick();

        // Fill, stall the fifth, then drain in order
        for (int k = 1; k <= 4; k++) push_rec(1'b1, 32'(k), 5'(k));
        chk("fill_lvl4", 64'(level), 64'(4));
        wr_wb_e = 1; wr_data = 32'd5; wr_idx = 5'd5; wr_req = 1;
        repeat (3) begin
            tick();
            chk("full_noack", 64'(wr_ack), 64'(0));
        end
        buf_re = 1;
        tick();
        chk("fill_pop1", 64'(din), 64'(1));
        chk("fill_same_edge_noack", 64'(wr_ack), 64'(0));
        buf_re = 0;
        tick();
        chk("fill_5_ack", 64'(wr_ack), 64'(1));
        wr_req = 0;
        tick();
        for (int k = 2; k <= 5; k++) pop_one("fill_order", 32'(k));

        // Wrap-around
        for (int k = 0; k < 10; k++) begin
            push_rec(1'b1, 32'(100 + k), 5'(k));
            chk("wrap_lvl", 64'(level <= 1), 64'(1));
            pop_one("wrap_din", 32'(100 + k));
        end

        // Concurrent push and pop at level 2
        push_rec(1'b1, 32'hA1, 5'd1);
        push_rec(1'b0, 32'hB2, 5'd2);
        wr_wb_e = 1; wr_data = 32'hC3; wr_idx = 5'd3; wr_req = 1; buf_re = 1;
        tick();
        chk("cc_wack", 64'(wr_ack),   64'(1));
        chk("cc_rack", 64'(buf_rack), 64'(1));
        chk("cc_lvl",  64'(level),    64'(2));
        chk("cc_din",  64'(din),      64'(32'hA1));
        wr_req = 0; buf_re = 0;
        tick();
        pop_one("cc_b", 32'hB2);
        pop_one("cc_c", 32'hC3);

        // Bypass / no-bypass timing from an empty buffer
        buf_re = 1;
        tick();
        wr_wb_e = 0; wr_data = 32'h7; wr_idx = 5'd0; wr_req = 1;
        tick();
        chk("byp_wack", 64'(wr_ack), 64'(1));
        wr_req = 0;
        if (BYP) begin
            chk("byp_same_cycle", 64'(buf_rack), 64'(1));
            chk("byp_e",   64'(wb_e),  64'(0));
            chk("byp_din", 64'(din),   64'(7));
            chk("byp_lvl", 64'(level), 64'(0));
            tick();
        end else begin
            chk("nobyp_not_same", 64'(buf_rack), 64'(0));
            tick();
            chk("nobyp_next", 64'(buf_rack), 64'(1));
            chk("nobyp_e",   64'(wb_e), 64'(0));
            chk("nobyp_din", 64'(din),  64'(7));
        end
        buf_re = 0;
        tick();

        // Randomized traffic with occasional reset
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 350) do_reset();
            if (!wr_req || wr_ack) begin
                if ($urandom_range(0, 2) != 0) begin
                    wr_req = 1; wr_wb_e = 1'($urandom);
                    wr_data = $urandom; wr_idx = 5'($urandom);
                end else wr_req = 0;
            end else if ($urandom_range(0, 15) == 0) wr_req = 0;
            buf_re = ($urandom_range(0, 99) < ((c < 1500) ? 35 : 80));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
